// File: rtl/pulse_period_meter_if.sv
// Period stream from pulse_period_meter to a logging/checking stage.
// Valid/ready handshake carrying the captured interval and its saturation flag.
interface pulse_period_meter_if #(
  parameter int unsigned CNT_W = 16
);
  logic [CNT_W-1:0] period;
  logic             period_sat;
  logic             period_valid;
  logic             period_ready;

  modport master (
    output period,
    output period_sat,
    output period_valid,
    input  period_ready
  );

  modport slave (
    input  period,
    input  period_sat,
    input  period_valid,
    output period_ready
  );
endinterface

// File: rtl/pulse_period_meter.sv
// Measures clk-cycle intervals between rising edges of pulse, counts edges,
// tracks min/max period and streams each captured period over valid/ready.
module pulse_period_meter #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned EVT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pulse,
  input  logic                  en,
  input  logic                  clr,
  pulse_period_meter_if.master  per_if,
  output logic                  overrun,
  output logic [EVT_W-1:0]      evt_cnt,
  output logic [CNT_W-1:0]      min_period,
  output logic [CNT_W-1:0]      max_period
);

  typedef enum logic [1:0] {StIdle, StWaitFirst, StMeasure} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [EVT_W-1:0] EvtOne = EVT_W'(1);

  state_e           state_q;
  logic             pulse_d_q;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] period_q;
  logic             period_sat_q;
  logic             valid_q;
  logic             overrun_q;
  logic [EVT_W-1:0] evt_q;
  logic [CNT_W-1:0] min_q;
  logic [CNT_W-1:0] max_q;

  logic edge_det;
  logic take;

  assign edge_det = pulse & ~pulse_d_q;
  assign take     = valid_q & per_if.period_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pulse_d_q    <= 1'b0;
      gap_q        <= '0;
      period_q     <= '0;
      period_sat_q <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      evt_q        <= '0;
      min_q        <= '1;
      max_q        <= '0;
    end else begin
      pulse_d_q <= pulse;
      if (clr) begin
        // period/period_sat deliberately hold across a clear
        evt_q     <= '0;
        min_q     <= '1;
        max_q     <= '0;
        overrun_q <= 1'b0;
        valid_q   <= 1'b0;
        gap_q     <= '0;
        state_q   <= en ? StWaitFirst : StIdle;
      end else begin
        if (take) begin
          valid_q <= 1'b0;
        end
        if (!en) begin
          state_q <= StIdle;
          gap_q   <= '0;
        end else begin
          unique case (state_q)
            StIdle: begin
              state_q <= StWaitFirst;
              gap_q   <= '0;
            end
            StWaitFirst: begin
              if (edge_det) begin
                state_q <= StMeasure;
                gap_q   <= CntOne;
                evt_q   <= evt_q + EvtOne;
              end
            end
            StMeasure: begin
              if (edge_det) begin
                period_q     <= gap_q;
                period_sat_q <= (gap_q == '1);
                min_q        <= (gap_q < min_q) ? gap_q : min_q;
                max_q        <= (gap_q > max_q) ? gap_q : max_q;
                valid_q      <= 1'b1;
                // Overwriting a value the consumer has not taken
                if (valid_q && !per_if.period_ready) begin
                  overrun_q <= 1'b1;
                end
                gap_q <= CntOne;
                evt_q <= evt_q + EvtOne;
              end else if (gap_q != '1) begin
                gap_q <= gap_q + CntOne;
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

  assign per_if.period       = period_q;
  assign per_if.period_sat   = period_sat_q;
  assign per_if.period_valid = valid_q;
  assign overrun             = overrun_q;
  assign evt_cnt             = evt_q;
  assign min_period          = min_q;
  assign max_period          = max_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: a 16-bit instance for the main
// behaviour and a CNT_W=4 instance for period saturation.
module tb_pulse_period_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pulse = 1'b0, en = 1'b0, clr = 1'b0;
  logic pulse4 = 1'b0, en4 = 1'b0, clr4 = 1'b0;

  logic        overrun, overrun4;
  logic [15:0] evt_cnt, evt_cnt4;
  logic [15:0] min_period, max_period;
  logic [3:0]  min4, max4;

  int errors = 0;
  int checks = 0;

  pulse_period_meter_if #(.CNT_W(16)) pif ();
  pulse_period_meter_if #(.CNT_W(4))  pif4 ();

  pulse_period_meter #(.CNT_W(16), .EVT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .pulse      (pulse),
    .en         (en),
    .clr        (clr),
    .per_if     (pif.master),
    .overrun    (overrun),
    .evt_cnt    (evt_cnt),
    .min_period (min_period),
    .max_period (max_period)
  );

  pulse_period_meter #(.CNT_W(4), .EVT_W(16)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .pulse      (pulse4),
    .en         (en4),
    .clr        (clr4),
    .per_if     (pif4.master),
    .overrun    (overrun4),
    .evt_cnt    (evt_cnt4),
    .min_period (min4),
    .max_period (max4)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic fire();
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
  endtask

  task automatic fire4();
    pulse4 = 1'b1;
    tick();
    pulse4 = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    pif.period_ready  = 1'b0;
    pif4.period_ready = 1'b0;
    #12;
    check_eq("rst_period", pif.period, 0);
    check_eq("rst_valid", pif.period_valid, 0);
    check_eq("rst_min", min_period, 16'hffff);
    check_eq("rst_max", max_period, 0);
    check_eq("rst_evt", evt_cnt, 0);
    rst = 1'b0;

    // Pulse every 10 cycles
    en = 1'b1;
    pif.period_ready = 1'b1;
    tick();
    fire();
    check_eq("t1_first_evt", evt_cnt, 1);
    check_eq("t1_first_novalid", pif.period_valid, 0);
    for (int i = 0; i < 4; i++) begin
      wait_n(9);
      fire();
      check_eq("t1_period", pif.period, 10);
      check_eq("t1_valid", pif.period_valid, 1);
    end
    check_eq("t1_evt", evt_cnt, 5);
    check_eq("t1_min", min_period, 10);
    check_eq("t1_max", max_period, 10);
    check_eq("t1_overrun", overrun, 0);
    tick();
    check_eq("t1_consumed", pif.period_valid, 0);

    // Intervals 7, 12, 4 after a clear
    do_clr();
    check_eq("clr_evt", evt_cnt, 0);
    check_eq("clr_min", min_period, 16'hffff);
    check_eq("clr_max", max_period, 0);
    check_eq("clr_period_hold", pif.period, 10);
    fire();
    wait_n(6);  fire(); check_eq("t2_p7", pif.period, 7);
    wait_n(11); fire(); check_eq("t2_p12", pif.period, 12);
    wait_n(3);  fire(); check_eq("t2_p4", pif.period, 4);
    check_eq("t2_min", min_period, 4);
    check_eq("t2_max", max_period, 12);

    // Backpressure and overrun
    pif.period_ready = 1'b0;
    do_clr();
    fire();
    wait_n(5); fire();
    check_eq("t3_valid2", pif.period_valid, 1);
    check_eq("t3_ovr2", overrun, 0);
    check_eq("t3_p6", pif.period, 6);
    wait_n(5); fire();
    check_eq("t3_ovr3", overrun, 1);
    pif.period_ready = 1'b1;
    tick();
    pif.period_ready = 1'b0;
    check_eq("t3_drained", pif.period_valid, 0);
    check_eq("t3_ovr_sticky", overrun, 1);
    do_clr();
    check_eq("t3_clr_ovr", overrun, 0);
    fire();
    wait_n(5); fire();
    wait_n(5);
    pif.period_ready = 1'b1;
    fire();
    check_eq("t3_same_cycle_valid", pif.period_valid, 1);
    check_eq("t3_same_cycle_ovr", overrun, 0);
    tick();
    check_eq("t3_same_cycle_drain", pif.period_valid, 0);

    // Wide pulses: 8 high, 8 low
    do_clr();
    for (int i = 0; i < 3; i++) begin
      pulse = 1'b1;
      tick();
      if (i > 0) check_eq("t5_p16", pif.period, 16);
      check_eq("t5_evt", evt_cnt, 32'(i + 1));
      wait_n(7);
      pulse = 1'b0;
      wait_n(8);
    end

    // Async reset mid-interval, clr with coincident edge, en toggle
    fire();
    wait_n(3);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_period", pif.period, 0);
    check_eq("t6_rst_evt", evt_cnt, 0);
    check_eq("t6_rst_min", min_period, 16'hffff);
    check_eq("t6_rst_max", max_period, 0);
    rst = 1'b0;
    clr = 1'b1;
    pulse = 1'b1;
    tick();
    clr = 1'b0;
    pulse = 1'b0;
    check_eq("t6_clr_edge_evt", evt_cnt, 0);
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    fire();
    check_eq("t6_first_evt", evt_cnt, 1);
    check_eq("t6_first_novalid", pif.period_valid, 0);
    wait_n(8); fire();
    check_eq("t6_p9", pif.period, 9);
    check_eq("t6_evt2", evt_cnt, 2);
    check_eq("t6_min", min_period, 9);

    // Saturation with CNT_W=4
    en4 = 1'b1;
    pif4.period_ready = 1'b1;
    tick();
    fire4();
    wait_n(19); fire4();
    check_eq("t4_p_sat", pif4.period, 15);
    check_eq("t4_sat", pif4.period_sat, 1);
    check_eq("t4_max", max4, 15);
    wait_n(4); fire4();
    check_eq("t4_p5", pif4.period, 5);
    check_eq("t4_nosat", pif4.period_sat, 0);
    check_eq("t4_min", min4, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Sits directly downstream of chip_top and consumes its `pulse` output.
- Measures the clk-cycle interval between consecutive pulse rising edges and counts the edges.
- Tracks the minimum and maximum period seen since the last clear.
- Delivers each measured period over a valid/ready interface to a logging or checking stage.

Parameters:
CNT_W, 16, width of the period counter and period/min/max outputs
EVT_W, 16, width of the event (edge) counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
pulse  in  1  pulse from chip_top; any width, treated as a level and rising-edge detected
en  in  1  measurement enable
clr  in  1  synchronous clear of statistics and measurement state
period  out  CNT_W  last captured interval in clk cycles
period_sat  out  1  captured period hit saturation (all ones)
period_valid  out  1  period holds an unconsumed value
period_ready  in  1  consumer accepts period when valid&ready
overrun  out  1  sticky: a capture overwrote an unconsumed value
evt_cnt  out  EVT_W  rising edges seen while enabled, wraps modulo 2^EVT_W
min_period  out  CNT_W  smallest captured period since clear
max_period  out  CNT_W  largest captured period since clear

Behaviour:
- Reset (async, immediate, including mid-measurement):
  - state=IDLE; pulse_d=0; gap=0.
  - period=0, period_sat=0, period_valid=0, overrun=0, evt_cnt=0, max_period=0.
  - min_period=all ones.
- Edge detect: edge = pulse & ~pulse_d, with pulse_d registered every cycle regardless of en. Because pulse_d resets to 0, pulse high on the first post-reset cycle counts as an edge.
- States:
  - IDLE: en=0. Edges ignored, gap held at 0. Outputs hold; a pending period_valid can still be consumed. en=1 -> WAIT_FIRST.
  - WAIT_FIRST: on edge -> MEASURE, gap<=1, evt_cnt++. No capture.
  - MEASURE: each non-edge cycle gap<=gap+1, saturating at 2^CNT_W-1. On edge: capture, then gap<=1, evt_cnt++.
  - en=0 in any state -> IDLE next cycle. The gap in progress is discarded; the first edge after re-enable only restarts measurement.
- Period definition: edges on cycles t0 and t1 capture period=t1-t0. A 1-cycle pulse every N cycles yields period=N.
- Minimum legal period is 2, since pulse must drop for at least one cycle between edges.
- Capture (one cycle, registered; visible the cycle after the edge):
  - period<=gap; period_sat<=(gap==all ones).
  - min_period<=min(min_period,gap); max_period<=max(max_period,gap). Saturated values participate.
  - period_valid<=1.
- Handshake:
  - valid&ready with no capture -> period_valid<=0 next cycle. period and period_sat hold their values.
  - Capture while valid&!ready -> new value overwrites, valid stays 1, overrun<=1 (sticky).
  - Capture with valid&ready in the same cycle -> new value loaded, valid stays 1, no overrun.
- clr (synchronous, highest priority after rst; an edge in the same cycle is ignored for capture and counting):
  - evt_cnt=0, min_period=all ones, max_period=0, overrun=0, period_valid=0, gap=0.
  - State -> WAIT_FIRST if en else IDLE. period and period_sat hold.
- evt_cnt wraps from 2^EVT_W-1 to 0 with no flag.
- No combinational path from period_ready to any output.

Test Plan:
- 1-cycle pulse every 10 cycles, en=1, period_ready=1 -> first capture period=10, every capture thereafter period=10. After 5 edges: evt_cnt=5, min_period=10, max_period=10, overrun=0.
- Intervals 7, 12, 4 with period_ready=1 -> captured values 7, 12, 4 in order; min_period=4, max_period=12.
- period_ready=0, pulse every 6 cycles for 3 edges -> period_valid=1 after the 2nd edge; overrun=1 after the 3rd. Raise ready one cycle -> period_valid=0 next cycle.
- CNT_W=4, edges 20 cycles apart -> period=15, period_sat=1, max_period=15. Next interval 5 -> period=5, period_sat=0.
- Pulse held high for 8 cycles, period 16 -> exactly one edge per pulse; period=16, evt_cnt increments by 1 per pulse.
- rst asserted asynchronously mid-interval, then clr with a coincident edge, then en toggled low/high -> all outputs reset immediately. The clr-cycle edge is not counted. After re-enable, the first edge yields no capture; the second captures the correct interval.
